arbiter8way16: RTL
==================

Name: arbiter8way16

Overview:
- Round-robin arbiter that shares one 16-bit output path between 8 requesters.
- Internally instantiates one _mux8way16, driven by a registered select.
- Adds a valid/ready handshake toward the consumer and a per-grant burst limit.
- Sits between the 16-bit gate-level muxes and any future bus or memory client; first sequential controller for the 16-bit datapath.

Parameters:
- BURST_MAX, 4: maximum accepted beats per grant before forced rotation; legal range 1..15.

Ports:
- in_clk  input  1  clock, rising edge
- in_rst_n  input  1  reset, asynchronous assert, active-low
- in_req  input  [0:7]  request; bit i = requester i (requester 0 = in_a ... requester 7 = in_h)
- in_a..in_h  input  [0:15] each  requester data, 8 ports
- in_ready  input  1  consumer accepts beat this cycle
- out_gnt  output  [0:7]  one-hot grant, registered
- out_sel  output  [0:2]  encoded grant index, registered; out_sel[0] is MSB, matching _mux8way16
- out_valid  output  1  beat on out_y is valid
- out_y  output  [0:15]  _mux8way16(in_a..in_h, out_sel), combinational from registered out_sel

Behaviour:
- Reset (in_rst_n low, asynchronous):
  - state=IDLE, out_gnt=8'b0, out_sel=3'b000, ptr=0, beat_cnt=0.
  - out_valid=0; out_y follows in_a.
- Deassertion is synchronous to in_clk; the first arbitration occurs on the first rising edge after release.
- States: IDLE, GRANT.
- IDLE:
  - If in_req != 0 at an edge, pick the first set bit searching from ptr upward, mod 8.
  - Next cycle: out_gnt=one-hot(i), out_sel=i, beat_cnt=0, state=GRANT.
  - Latency from request to grant: 1 cycle.
  - If in_req == 0, stay in IDLE; out_gnt and out_sel hold their last values (out_gnt=0).
- GRANT, valid rule: out_valid = in_req[out_sel], combinational. The granted requester must hold data stable while its req is high.
- GRANT, transfer: a beat transfers on an edge where out_valid && in_ready; beat_cnt increments.
- GRANT, release occurs on an edge when either:
  - (a) in_req[out_sel]==0, or
  - (b) a transfer occurs with beat_cnt==BURST_MAX-1.
- On release:
  - ptr = out_sel+1 mod 8.
  - The next winner is chosen in the same edge from in_req using the new ptr. The released requester is lowest priority but still eligible.
  - If a winner exists, the grant switches back-to-back with no idle cycle and beat_cnt=0. Otherwise state=IDLE and out_gnt=0.
- No transfer while in_ready=0: the grant is held indefinitely and beat_cnt is unchanged.
- The req drop in (a) wins over everything; no beat is counted that cycle because out_valid=0.
- Simultaneous requests: strictly round-robin from ptr; no requester waits more than 7 grants.
- BURST_MAX=1: rotate after every accepted beat.
- A single requester held high is re-granted back-to-back indefinitely, with beat_cnt reset at each rotation.
- Reset asserted mid-grant: immediate return to reset values. The in-flight beat is dropped, with no partial-state retention.

Optional Feature:
- Macro: ARBITER8WAY16_LOCK_EN.
- Defined:
  - Adds input port in_lock (1 bit), placed after in_ready.
  - While in_lock=1 in GRANT, release condition (b) is suppressed and beat_cnt saturates at BURST_MAX-1.
  - Release (a) still applies.
  - in_lock is ignored in IDLE.
- Undefined: no in_lock port; burst limit is always enforced.

Test Plan:
- Reset with in_req=8'hFF held → out_gnt=0, out_valid=0 while in_rst_n=0. First edge after release → out_gnt=8'b1000_0000, out_sel=3'b000, out_y=in_a.
- in_req=8'b0010_0000 (requester 2) only, in_c=16'hBEEF, in_ready=1 → grant 1 cycle after request, out_y=16'hBEEF, out_valid=1. Grant re-issued after 4 beats (BURST_MAX=4) with no gap.
- in_req=8'hFF, in_ready=1, BURST_MAX=4 → grants rotate 0,1,2,...,7,0, each holding exactly 4 accepted beats; no idle cycles between grants.
- Requester 3 granted, in_ready=0 for 10 cycles → out_gnt stable, beat_cnt=0. Then in_ready=1 for 4 cycles → rotate to next requester.
- Requester 5 drops req after 2 beats, in_req otherwise 0 → IDLE next cycle, out_valid=0. A later in_req=8'b1000_0100 grants requester 0 before 5, since ptr=6.
- With ARBITER8WAY16_LOCK_EN, in_lock=1, in_req=8'hC0 → requester 0 holds for 12 beats. in_lock falls → rotate to requester 1 after the next accepted beat.

Source files
------------

// File: rtl/arbiter8way16.sv
// rtl/arbiter8way16.sv - round-robin 8-way 16-bit arbiter with valid/ready and burst limit
// Optional burst lock input enabled by defining ARBITER8WAY16_LOCK_EN.
module arbiter8way16 #(
    parameter int BURST_MAX = 4
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [0:7]  in_req,
    input  logic [0:15] in_a,
    input  logic [0:15] in_b,
    input  logic [0:15] in_c,
    input  logic [0:15] in_d,
    input  logic [0:15] in_e,
    input  logic [0:15] in_f,
    input  logic [0:15] in_g,
    input  logic [0:15] in_h,
    input  logic        in_ready,
`ifdef ARBITER8WAY16_LOCK_EN
    input  logic        in_lock,
`endif
    output logic [0:7]  out_gnt,
    output logic [0:2]  out_sel,
    output logic        out_valid,
    output logic [0:15] out_y
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

    state_t      state, state_n;
    logic [0:7]  gnt_n;
    logic [0:2]  sel_n;
    logic [2:0]  ptr, ptr_n;
    logic [3:0]  beat_cnt, beat_n;
    logic [2:0]  base, cand, pick;
    logic        found, lock, xfer, release_now;

`ifdef ARBITER8WAY16_LOCK_EN
    assign lock = in_lock;
`else
    assign lock = 1'b0;
`endif

    assign out_valid = (state == GRANT) && in_req[out_sel];
    assign xfer      = out_valid && in_ready;

    // On release the search starts just past the current holder, so it is
    // evaluated with the post-release pointer in the same edge.
    assign base = (state == GRANT) ? 3'(out_sel + 3'd1) : ptr;

    always_comb begin
        pick  = base;
        found = 1'b0;
        cand  = base;
        for (int k = 7; k >= 0; k--) begin
            cand = 3'(base + 3'(k));
            if (in_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = !in_req[out_sel] ||
                         (xfer && (beat_cnt == BEAT_LAST) && !lock);

    always_comb begin
        state_n = state;
        gnt_n   = out_gnt;
        sel_n   = out_sel;
        ptr_n   = ptr;
        beat_n  = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    sel_n       = pick;
                    beat_n      = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_n  = base;
                    gnt_n  = '0;
                    beat_n = '0;
                    if (found) begin
                        gnt_n[pick] = 1'b1;
                        sel_n       = pick;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer && (beat_cnt != BEAT_LAST)) begin
                    // Under lock the count saturates at the last beat.
                    beat_n = beat_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= IDLE;
            out_gnt  <= '0;
            out_sel  <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            out_gnt  <= gnt_n;
            out_sel  <= sel_n;
            ptr      <= ptr_n;
            beat_cnt <= beat_n;
        end
    end

    _mux8way16 u_mux (
        .in_a   (in_a),
        .in_b   (in_b),
        .in_c   (in_c),
        .in_d   (in_d),
        .in_e   (in_e),
        .in_f   (in_f),
        .in_g   (in_g),
        .in_h   (in_h),
        .in_sel (out_sel),
        .out_y  (out_y)
    );

endmodule

// 8-way 16-bit mux; in_sel[0] is the MSB of the index.
module _mux8way16 (
    input  logic [0:15] in_a,
    input  logic [0:15] in_b,
    input  logic [0:15] in_c,
    input  logic [0:15] in_d,
    input  logic [0:15] in_e,
    input  logic [0:15] in_f,
    input  logic [0:15] in_g,
    input  logic [0:15] in_h,
    input  logic [0:2]  in_sel,
    output logic [0:15] out_y
);

    always_comb begin
        case (in_sel)
            3'd0:    out_y = in_a;
            3'd1:    out_y = in_b;
            3'd2:    out_y = in_c;
            3'd3:    out_y = in_d;
            3'd4:    out_y = in_e;
            3'd5:    out_y = in_f;
            3'd6:    out_y = in_g;
            default: out_y = in_h;
        endcase
    end

endmodule
